// File: rtl/zcmt_jt_responder_if.sv
// Request/response bus of the jump-table responder: index phase, tag phase,
// kill, and the single-beat read response with its error flag.
interface zcmt_jt_responder_if;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [1:0]  data_size_i;
  logic        data_id_i;
  logic [31:0] data_wdata_i;
  logic [9:0]  address_index_i;
  logic [23:0] address_tag_i;
  logic        tag_valid_i;
  logic        kill_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_rid_o;
  logic [31:0] data_rdata_o;
  logic        err_o;

  // Handshake: a request is accepted on any cycle where data_req_i and
  // data_gnt_o are both high; the requester keeps data_req_i and its index
  // phase fields stable until then. The tag phase is consumed on the first
  // cycle after the grant where tag_valid_i or kill_req_i is high. Read data
  // is a one-cycle data_rvalid_o pulse with no backpressure.
  modport master (
    output data_req_i, data_we_i, data_be_i, data_size_i, data_id_i,
    output data_wdata_i, address_index_i, address_tag_i, tag_valid_i, kill_req_i,
    input  data_gnt_o, data_rvalid_o, data_rid_o, data_rdata_o, err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_size_i, data_id_i,
    input  data_wdata_i, address_index_i, address_tag_i, tag_valid_i, kill_req_i,
    output data_gnt_o, data_rvalid_o, data_rid_o, data_rdata_o, err_o
  );
endinterface

// File: rtl/zcmt_jt_responder.sv
// Memory-mapped jump-table responder: a small word-addressed table behind a
// split index/tag request bus with one outstanding transaction at a time.
module zcmt_jt_responder #(
  parameter logic [33:0] BASE_ADDR = 34'h0_0000_0000,
  parameter int unsigned ENTRIES   = 256,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  zcmt_jt_responder_if.slave      bus,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  index_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q;
  logic        id_q;
  logic [31:0] wdata_q;
  logic [7:0]  word_q;
  logic        legal_q;
  logic [3:0]  cnt_q;
  logic        err_wr_q;
  logic [31:0] table_q [ENTRIES];

  logic [33:0] addr;
  logic [33:0] off;
  logic [31:0] word;
  logic        legal;
  logic        tag_fire;
  logic        wr_fire;
  logic        resp;

  always_comb begin
    addr     = {bus.address_tag_i, index_q};
    off      = addr - BASE_ADDR;
    word     = off[33:2];
    legal    = (addr >= BASE_ADDR) && (word < ENTRIES) &&
               (off[1:0] == 2'b00) && (size_q == 2'b10);
    tag_fire = (state_q == TAG) && bus.tag_valid_i && !bus.kill_req_i;
    wr_fire  = tag_fire && we_q && legal;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.data_req_i) state_d = TAG;
      TAG: begin
        if (bus.kill_req_i) state_d = IDLE;
        else if (bus.tag_valid_i) begin
          if (we_q) state_d = IDLE;
          else      state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: if (cnt_q == 4'd1) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      index_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      size_q   <= '0;
      id_q     <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
      legal_q  <= 1'b0;
      cnt_q    <= '0;
      err_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_wr_q <= 1'b0;
      if (state_q == IDLE && bus.data_req_i) begin
        index_q <= bus.address_index_i;
        we_q    <= bus.data_we_i;
        be_q    <= bus.data_be_i;
        size_q  <= bus.data_size_i;
        id_q    <= bus.data_id_i;
        wdata_q <= bus.data_wdata_i;
      end
      // Illegal writes report one cycle late; reads report in RESP.
      if (tag_fire) begin
        if (we_q) begin
          err_wr_q <= !legal;
        end else begin
          word_q  <= word[7:0];
          legal_q <= legal;
          cnt_q   <= 4'(LATENCY - 1);
        end
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) table_q[i] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) table_q[word[7:0]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // Response outputs are forced quiet while reset is asserted.
  assign resp              = (state_q == RESP) && !rst_i;
  assign bus.data_gnt_o    = (state_q == IDLE) && bus.data_req_i;
  assign bus.data_rvalid_o = resp;
  assign bus.data_rid_o    = resp ? id_q : 1'b0;
  assign bus.data_rdata_o  = (resp && legal_q) ? table_q[word_q] : 32'h0;
  assign bus.err_o         = !rst_i && (err_wr_q || ((state_q == RESP) && !legal_q));
  assign dbg_state_o       = state_q;

endmodule

// File: doc/zcmt_jt_responder.md
ZCMT_JT_RESPONDER -- requirements
Module: zcmt_jt_responder

Interface
REQ-001 Parameter BASE_ADDR, default 34'h0000_0000: physical byte address of table entry 0, word aligned.
REQ-002 Parameter ENTRIES, default 256: number of 32-bit table words, range 1..256.
REQ-003 Parameter LATENCY, default 2: cycles from tag phase to data_rvalid_o, range 1..15.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 data_req_i  in  1  request valid, index phase.
REQ-007 data_we_i  in  1  1 = write, 0 = read.
REQ-008 data_be_i  in  4  write byte enables.
REQ-009 data_size_i  in  2  access size; only 2'b10 (word) is legal.
REQ-010 data_id_i  in  1  transaction id, returned on data_rid_o.
REQ-011 data_wdata_i  in  32  write data, index phase.
REQ-012 address_index_i  in  10  low address bits, index phase.
REQ-013 address_tag_i  in  24  high address bits, tag phase.
REQ-014 tag_valid_i  in  1  tag phase valid.
REQ-015 kill_req_i  in  1  cancel accepted request during tag phase.
REQ-016 data_gnt_o  out  1  request accepted.
REQ-017 data_rvalid_o  out  1  read data valid, one-cycle pulse.
REQ-018 data_rid_o  out  1  id of returned read.
REQ-019 data_rdata_o  out  32  read data.
REQ-020 err_o  out  1  one-cycle pulse: out-of-window, misaligned or illegal-size access.

Function
REQ-021 States: IDLE, TAG, WAIT, RESP; single outstanding transaction.
REQ-022 data_gnt_o = data_req_i while state is IDLE; 0 in every other state.
REQ-023 IDLE, data_req_i=1 -> capture index, we, be, size, id, wdata; next state TAG.
REQ-024 TAG, kill_req_i=1 -> drop transaction, no write, no rvalid, no err; next IDLE (kill has priority over tag_valid_i).
REQ-025 TAG, tag_valid_i=0 and kill_req_i=0 -> stay in TAG.
REQ-026 TAG, tag_valid_i=1 -> addr = {address_tag_i, captured index} (34 bits); off = addr - BASE_ADDR (34-bit, unsigned wrap); word = off[33:2].
REQ-027 Access legal iff addr >= BASE_ADDR, word < ENTRIES, off[1:0]==0, size==2'b10.
REQ-028 Legal write: in the TAG-exit cycle, update table[word] bytes whose data_be bit is 1; next IDLE; no rvalid.
REQ-029 Illegal write: table unchanged; err_o pulses the cycle after TAG exit; next IDLE.
REQ-030 Read: latch word, legality and id; load counter with LATENCY-1; next WAIT if LATENCY>1, else RESP.
REQ-031 WAIT: decrement counter each cycle; counter==1 -> RESP.
REQ-032 RESP: data_rvalid_o=1, data_rid_o=latched id; data_rdata_o = table[word] if legal, else 32'h0 with err_o=1; next IDLE.
REQ-033 Read latency: data_rvalid_o exactly LATENCY cycles after the tag_valid_i cycle.
REQ-034 Read data reflects the table content at RESP, including a write committed earlier.
REQ-035 data_rdata_o = 0 and data_rvalid_o = 0 whenever state is not RESP.
REQ-036 data_req_i outside IDLE is ignored (no gnt); the requester holds it; grant in the first IDLE cycle after RESP.
REQ-037 kill_req_i outside TAG has no effect.
REQ-038 Unused data_be_i and data_wdata_i on reads are ignored.

Reset
REQ-039 rst_i=1 at a clock edge -> state IDLE, counter 0, all table words 32'h0, latched fields 0.
REQ-040 During and after reset: data_gnt_o follows REQ-022 from IDLE; data_rvalid_o=0, data_rid_o=0, data_rdata_o=0, err_o=0.
REQ-041 Reset in TAG, WAIT or RESP aborts the transaction; no rvalid or err is produced for it afterwards.

Verification
REQ-042 Write BASE+0x8, wdata 32'h8000_1234, be 4'hF; read BASE+0x8, id 1, LATENCY 2 -> rvalid two cycles after tag, rdata 32'h8000_1234, rid 1.
REQ-043 Write BASE+0x4 32'hFFFF_FFFF; then write be 4'b0011 data 32'h0000_ABCD; read -> 32'hFFFF_ABCD.
REQ-044 Read with word = ENTRIES (BASE+0x400 for 256 entries) -> rvalid, rdata 0, err_o=1; table unchanged.
REQ-045 Grant, then kill_req_i=1 with tag_valid_i=1 in the tag phase -> no rvalid, no err, table unchanged, gnt again next cycle.
REQ-046 Hold data_req_i during WAIT -> gnt=0 until the cycle after RESP, then gnt=1.
REQ-047 Assert rst_i in WAIT after a write of 32'h5 to BASE+0x0 -> no rvalid afterwards; a read of BASE+0x0 returns 0.
